// File: rtl/hex_cmd_pkg.sv
// hex_cmd_pkg: shared definitions for the ASCII hex command parser.
//   state_t          - parser / reply sequencer states
//   CH_*             - ASCII character constants used by the parser and replies
//   nibble_to_ascii  - 4-bit value to uppercase ASCII hex digit
package hex_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SKIP,
    EXEC,
    RD_WAIT,
    TX_LOAD,
    TX_ACK,
    TX_DONE
  } state_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_QM = 8'h3F;

  // Replies always use uppercase letters.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    logic [7:0] ext;
    ext = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + ext) : (8'h37 + ext);
  endfunction

endpackage

// File: rtl/ascii_to_nibble.sv
// ascii_to_nibble: combinational ASCII hex digit decoder.
//   ch     (in,  8) - received character
//   nibble (out, 4) - decoded value, 0 when ch is not a hex digit
//   is_hex (out, 1) - ch is one of 0-9, A-F, a-f
module ascii_to_nibble (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: collects "W aa dd<CR>" / "R aa<CR>" commands from uart_rx,
// executes them on an 8-bit register port and returns an ASCII reply
// ("K", two hex digits, or "?", each followed by CR LF) through uart_tx.
//   clk, resetn           - clock, synchronous active-low reset
//   rx_valid, rx_data     - received character strobe and data
//   reg_wr, reg_rd        - one-cycle register write / read strobes
//   reg_addr, reg_wdata   - register address / write data, held between commands
//   reg_rdata             - read data, valid the cycle after reg_rd
//   tx_en, tx_data        - transmit strobe and held reply character
//   tx_busy               - transmitter busy flag
//   rx_drop               - sticky: a character arrived while busy executing/replying
module hex_cmd_parser
  import hex_cmd_pkg::*;
#(
  parameter int CMD_MAX = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       rx_drop
);

  // A command never holds more than 4 digits; a smaller CMD_MAX tightens that.
  localparam logic [2:0] DIG_LIMIT = (CMD_MAX < 4) ? 3'(CMD_MAX) : 3'd4;

  localparam logic [31:0] REPLY_ERR = {CH_QM, CH_CR, CH_LF, 8'h00};
  localparam logic [31:0] REPLY_OK  = {CH_K,  CH_CR, CH_LF, 8'h00};

  state_t      state;
  logic        is_write;
  logic [2:0]  dig_cnt;
  logic [15:0] acc;
  // Reply buffer: the character currently on tx_data sits in [31:24].
  logic [31:0] reply;
  logic [2:0]  reply_len;

  logic [3:0]  rx_nibble;
  logic        rx_is_hex;
  logic        rx_is_w;
  logic        rx_is_r;
  logic        rx_is_cr;
  logic        rx_is_blank;
  logic        busy_state;

  ascii_to_nibble u_a2n (
    .ch     (rx_data),
    .nibble (rx_nibble),
    .is_hex (rx_is_hex)
  );

  assign rx_is_w     = (rx_data == 8'h57) || (rx_data == 8'h77);
  assign rx_is_r     = (rx_data == 8'h52) || (rx_data == 8'h72);
  assign rx_is_cr    = (rx_data == CH_CR);
  assign rx_is_blank = (rx_data == CH_SP) || (rx_data == CH_LF);
  assign busy_state  = (state == EXEC) || (state == RD_WAIT) || (state == TX_LOAD) ||
                       (state == TX_ACK) || (state == TX_DONE);

  // Outputs are registered and asserted on entry to EXEC / TX_LOAD, so the
  // strobes are visible during the state that owns them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      dig_cnt   <= 3'd0;
      acc       <= 16'h0000;
      reply     <= 32'h0;
      reply_len <= 3'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      rx_drop   <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      tx_en  <= 1'b0;

      if (rx_valid && busy_state) begin
        rx_drop <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_is_w || rx_is_r) begin
              is_write <= rx_is_w;
              dig_cnt  <= 3'd0;
              acc      <= 16'h0000;
              state    <= CMD;
            end else if (rx_is_cr) begin
              reply     <= REPLY_ERR;
              reply_len <= 3'd3;
              tx_data   <= CH_QM;
              tx_en     <= 1'b1;
              state     <= TX_LOAD;
            end else if (!rx_is_blank) begin
              state <= SKIP;
            end
          end
        end

        CMD: begin
          if (rx_valid) begin
            if (rx_is_hex) begin
              if (dig_cnt >= DIG_LIMIT) begin
                dig_cnt <= 3'd5;
                state   <= SKIP;
              end else begin
                acc     <= {acc[11:0], rx_nibble};
                dig_cnt <= dig_cnt + 3'd1;
              end
            end else if (rx_is_cr) begin
              if (is_write && dig_cnt == 3'd4) begin
                reg_addr  <= acc[15:8];
                reg_wdata <= acc[7:0];
                reg_wr    <= 1'b1;
                state     <= EXEC;
              end else if (!is_write && dig_cnt == 3'd2) begin
                reg_addr <= acc[7:0];
                reg_rd   <= 1'b1;
                state    <= EXEC;
              end else begin
                reply     <= REPLY_ERR;
                reply_len <= 3'd3;
                tx_data   <= CH_QM;
                tx_en     <= 1'b1;
                state     <= TX_LOAD;
              end
            end else if (!rx_is_blank) begin
              state <= SKIP;
            end
          end
        end

        SKIP: begin
          if (rx_valid && rx_is_cr) begin
            reply     <= REPLY_ERR;
            reply_len <= 3'd3;
            tx_data   <= CH_QM;
            tx_en     <= 1'b1;
            state     <= TX_LOAD;
          end
        end

        EXEC: begin
          if (is_write) begin
            reply     <= REPLY_OK;
            reply_len <= 3'd3;
            tx_data   <= CH_K;
            tx_en     <= 1'b1;
            state     <= TX_LOAD;
          end else begin
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          reply     <= {nibble_to_ascii(reg_rdata[7:4]), nibble_to_ascii(reg_rdata[3:0]),
                        CH_CR, CH_LF};
          reply_len <= 3'd4;
          tx_data   <= nibble_to_ascii(reg_rdata[7:4]);
          tx_en     <= 1'b1;
          state     <= TX_LOAD;
        end

        TX_LOAD: begin
          state <= TX_ACK;
        end

        TX_ACK: begin
          if (tx_busy) begin
            state <= TX_DONE;
          end
        end

        TX_DONE: begin
          if (!tx_busy) begin
            if (reply_len > 3'd1) begin
              reply     <= {reply[23:0], 8'h00};
              reply_len <= reply_len - 3'd1;
              tx_data   <= reply[23:16];
              tx_en     <= 1'b1;
              state     <= TX_LOAD;
            end else begin
              reply_len <= 3'd0;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_cmd_parser.sv
module tb_hex_cmd_parser;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rx_drop;

  hex_cmd_parser dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_drop   (rx_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] cmd;
    int          len;
    logic [7:0]  rdata;
    logic        exp_wr;
    logic        exp_rd;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [31:0] exp_reply;
    int          exp_len;
  } vec_t;

  localparam logic [31:0] R_K = {8'h4B, 8'h0D, 8'h0A, 8'h00};
  localparam logic [31:0] R_Q = {8'h3F, 8'h0D, 8'h0A, 8'h00};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_len = 40;
  int last_send_cyc = 0;
  logic [7:0] rd_value = 8'h00;
  bit stab_chk = 1'b1;

  // Monitor / uart_tx model state
  logic [7:0] txq[$];
  int         txc[$];
  bit         pending = 1'b0;
  int         dly = 0;
  int         hold = 0;
  logic [7:0] last_tx = 8'h00;
  int         wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
  int         ovl_err = 0, both_err = 0, stab_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read data is valid only in the cycle after reg_rd.
  always @(posedge clk) reg_rdata <= reg_rd ? rd_value : 8'h00;

  // tx_busy rises 3 cycles after tx_en and stays high busy_len cycles.
  always @(negedge clk) begin
    if (tx_en) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
      if (tx_busy || pending) ovl_err <= ovl_err + 1;
      last_tx <= tx_data;
      pending <= 1'b1;
      dly     <= 2;
    end else if (pending) begin
      if (stab_chk && tx_data !== last_tx) stab_err <= stab_err + 1;
      if (dly == 0) begin
        pending <= 1'b0;
        tx_busy <= 1'b1;
        hold    <= busy_len - 1;
      end else begin
        dly <= dly - 1;
      end
    end else if (tx_busy) begin
      if (stab_chk && tx_data !== last_tx) stab_err <= stab_err + 1;
      if (hold == 0) tx_busy <= 1'b0;
      else hold <= hold - 1;
    end
    if (reg_wr === 1'b1) begin
      wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; wr_addr <= reg_addr; wr_data <= reg_wdata;
    end
    if (reg_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; rd_addr <= reg_addr;
    end
    if (reg_wr === 1'b1 && reg_rd === 1'b1) both_err <= both_err + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string s, input logic [7:0] rdata, input logic wr,
                              input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [31:0] reply, input int rlen);
    vec_t v;
    v.cmd = 64'h0;
    for (int i = 0; i < s.len(); i++) v.cmd = {v.cmd[55:0], s[i]};
    v.len = s.len();
    v.rdata = rdata; v.exp_wr = wr; v.exp_rd = rd; v.exp_addr = addr;
    v.exp_wdata = wdata; v.exp_reply = reply; v.exp_len = rlen;
    return v;
  endfunction

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    rx_data = c; rx_valid = 1'b1;
    last_send_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input vec_t v, output int cr_cyc);
    rd_value = v.rdata;
    for (int k = 0; k < v.len; k++) send_char(v.cmd[8*(v.len-1-k) +: 8]);
    send_char(8'h0D);
    cr_cyc = last_send_cyc;
  endtask

  task automatic run_cmd(input string tag, input vec_t v, input bit inject, input logic exp_drop);
    int wr0, rd0, budget, n, cr_cyc, lat;
    wr0 = wr_cnt; rd0 = rd_cnt;
    txq.delete(); txc.delete();
    send_cmd(v, cr_cyc);
    if (inject) begin
      n = 0;
      while (txq.size() < 1 && n < 200) begin @(negedge clk); n++; end
      send_char(8'h52);
      check({tag, "_drop_set"}, int'(rx_drop), 1);
    end
    budget = v.exp_len * (busy_len + 20) + 200;
    n = 0;
    while (!(txq.size() >= v.exp_len && !tx_busy && !pending) && n < budget) begin
      @(negedge clk); n++;
    end
    check({tag, "_reply_timeout"}, int'(n < budget), 1);
    repeat (20) @(negedge clk);
    check({tag, "_wr_count"}, wr_cnt - wr0, int'(v.exp_wr));
    check({tag, "_rd_count"}, rd_cnt - rd0, int'(v.exp_rd));
    if (v.exp_wr) begin
      check({tag, "_wr_addr"}, int'(wr_addr), int'(v.exp_addr));
      check({tag, "_wr_data"}, int'(wr_data), int'(v.exp_wdata));
      check({tag, "_wr_lat"}, wr_cyc - cr_cyc, 1);
    end
    if (v.exp_rd) begin
      check({tag, "_rd_addr"}, int'(rd_addr), int'(v.exp_addr));
      check({tag, "_rd_lat"}, rd_cyc - cr_cyc, 1);
    end
    check({tag, "_reply_len"}, txq.size(), v.exp_len);
    for (int k = 0; k < v.exp_len; k++)
      check($sformatf("%s_char%0d", tag, k), (k < txq.size()) ? int'(txq[k]) : -1,
            int'(v.exp_reply[31-8*k -: 8]));
    lat = (txc.size() > 0) ? txc[0] - cr_cyc : -1;
    check({tag, "_tx_lat"}, lat, v.exp_wr ? 2 : (v.exp_rd ? 3 : 1));
    check({tag, "_rx_drop"}, int'(rx_drop), int'(exp_drop));
    check({tag, "_tx_overlap"}, ovl_err, 0);
    check({tag, "_strobe_both"}, both_err, 0);
    check({tag, "_tx_stable"}, stab_err, 0);
    $display("%s: cmd_len=%0d reply_chars=%0d wr=%0d rd=%0d", tag, v.len, txq.size(),
             wr_cnt - wr0, rd_cnt - rd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    vec_t v;
    int n, cr_cyc;

    vecs[0]  = mk("W3A5C",   8'h00, 1, 0, 8'h3A, 8'h5C, R_K, 3);
    vecs[1]  = mk("r 3a",    8'hE7, 0, 1, 8'h3A, 8'h00, {8'h45, 8'h37, 8'h0D, 8'h0A}, 4);
    vecs[2]  = mk("W12",     8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[3]  = mk("X",       8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[4]  = mk("R123",    8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[5]  = mk("w ff 0a", 8'h00, 1, 0, 8'hFF, 8'h0A, R_K, 3);
    vecs[6]  = mk("Rc4",     8'h09, 0, 1, 8'hC4, 8'h00, {8'h30, 8'h39, 8'h0D, 8'h0A}, 4);
    vecs[7]  = mk("",        8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[8]  = mk("W12345",  8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[9]  = mk("R 1g",    8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3);
    vecs[10] = mk("R\n55",   8'hA0, 0, 1, 8'h55, 8'h00, {8'h41, 8'h30, 8'h0D, 8'h0A}, 4);
    vecs[11] = mk(" W0123",  8'h00, 1, 0, 8'h01, 8'h23, R_K, 3);

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_reg_wr", int'(reg_wr), 0);
    check("rst_reg_rd", int'(reg_rd), 0);
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_rx_drop", int'(rx_drop), 0);
    check("rst_reg_addr", int'(reg_addr), 0);
    check("rst_reg_wdata", int'(reg_wdata), 0);
    check("rst_tx_data", int'(tx_data), 0);

    for (int i = 0; i < 12; i++) begin
      busy_len = (i == 1) ? 1000 : 40;
      run_cmd($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
    end
    busy_len = 40;

    // Character injected while the reply is in flight.
    run_cmd("drop", mk("R00", 8'h5A, 0, 1, 8'h00, 8'h00, {8'h35, 8'h41, 8'h0D, 8'h0A}, 4),
            1'b1, 1'b1);
    run_cmd("after_drop", mk("1", 8'h00, 0, 0, 8'h00, 8'h00, R_Q, 3), 1'b0, 1'b1);

    // Reset while the second reply character is being transmitted.
    txq.delete(); txc.delete();
    send_cmd(mk("R3a", 8'h12, 0, 1, 8'h3A, 8'h00, 32'h0, 4), cr_cyc);
    n = 0;
    while (txq.size() < 2 && n < 400) begin @(negedge clk); n++; end
    check("mid_rst_second_char", int'(txq.size() >= 2), 1);
    repeat (2) @(negedge clk);
    stab_chk = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_reg_wr", int'(reg_wr), 0);
    check("mid_rst_reg_rd", int'(reg_rd), 0);
    check("mid_rst_tx_en", int'(tx_en), 0);
    check("mid_rst_rx_drop", int'(rx_drop), 0);
    check("mid_rst_reg_addr", int'(reg_addr), 0);
    check("mid_rst_reg_wdata", int'(reg_wdata), 0);
    check("mid_rst_tx_data", int'(tx_data), 0);
    repeat (300) @(negedge clk);
    check("mid_rst_no_more_tx", txq.size(), 2);
    $display("mid_reset: chars_before_reset=%0d", txq.size());
    stab_chk = 1'b1;
    v = mk("W0101", 8'h00, 1, 0, 8'h01, 8'h01, R_K, 3);
    run_cmd("post_rst", v, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
